// File: rtl/mux_n_arb_if.sv
// Handshake bundle between the request sources and the arbitrated output register.
// The slave side is the arbiter; the master side drives requests, data and downstream ready.
interface mux_n_arb_if #(
    parameter int DATA_W = 323,
    parameter int N_CH   = 2
);
    localparam int SRC_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]        req;
    logic [N_CH*DATA_W-1:0] data_i;
    logic [N_CH-1:0]        grant;
    logic [DATA_W-1:0]      dout;
    logic [SRC_W-1:0]       src_id;
    logic                   valid;
    logic                   ready;

    modport master (
        output req, data_i, ready,
        input  grant, dout, src_id, valid
    );

    modport slave (
        input  req, data_i, ready,
        output grant, dout, src_id, valid
    );
endinterface

// File: rtl/mux_n_arb.sv
// N-channel arbitrated multiplexer feeding a one-entry valid/ready output register.
// Arbitration is fixed priority (lowest index) or round-robin starting at ptr_q.
module mux_n_arb #(
    parameter int DATA_W = 323,
    parameter int N_CH   = 2,
    parameter int RR_EN  = 0,
    localparam int SRC_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic       clk,
    input  logic       rst_n,
    mux_n_arb_if.slave bus
);
    logic [SRC_W-1:0]  ptr_q, ptr_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [SRC_W-1:0]  srcId_q, srcId_d;

    logic [N_CH-1:0]   maskHigh;
    logic [N_CH-1:0]   reqHigh;
    logic [SRC_W-1:0]  winner;
    logic              free;
    logic              load;

    // Round-robin: requesters at or above ptr take precedence; otherwise fall back to the lowest requester.
    always_comb begin
        maskHigh = '0;
        for (int k = 0; k < N_CH; k++) begin
            maskHigh[k] = (RR_EN != 0) && (k >= int'(ptr_q));
        end
        reqHigh = bus.req & maskHigh;
        winner  = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (bus.req[k]) winner = SRC_W'(k);
        end
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (reqHigh[k]) winner = SRC_W'(k);
        end
    end

    assign free      = !valid_q || bus.ready;
    assign load      = free && (|bus.req) && rst_n;
    assign bus.grant = load ? (N_CH'(1) << winner) : '0;

    always_comb begin
        valid_d = valid_q;
        dout_d  = dout_q;
        srcId_d = srcId_q;
        ptr_d   = ptr_q;
        if (load) begin
            dout_d  = bus.data_i[int'(winner)*DATA_W +: DATA_W];
            srcId_d = winner;
            valid_d = 1'b1;
            if (RR_EN != 0) begin
                ptr_d = (winner == SRC_W'(N_CH - 1)) ? '0 : winner + SRC_W'(1);
            end
        end else if (valid_q && bus.ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            dout_q  <= '0;
            srcId_q <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            dout_q  <= dout_d;
            srcId_q <= srcId_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.valid  = valid_q;
    assign bus.dout   = dout_q;
    assign bus.src_id = srcId_q;
endmodule

// File: tb/tb_mux_n_arb.sv
// Drives a fixed-priority and a round-robin 4-channel arbiter with identical stimulus and
// checks both against a queue-based reference model; a monitor pops words as they are accepted.
module tb_mux_n_arb;
    localparam int DW = 16;
    localparam int NC = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    src;
    } exp_t;

    logic clk;
    logic rstN;

    mux_n_arb_if #(.DATA_W(DW), .N_CH(NC)) ifFp ();
    mux_n_arb_if #(.DATA_W(DW), .N_CH(NC)) ifRr ();

    mux_n_arb #(.DATA_W(DW), .N_CH(NC), .RR_EN(0)) dutFp (.clk(clk), .rst_n(rstN), .bus(ifFp));
    mux_n_arb #(.DATA_W(DW), .N_CH(NC), .RR_EN(1)) dutRr (.clk(clk), .rst_n(rstN), .bus(ifRr));

    int   nCompared   = 0;
    int   nMismatched = 0;
    exp_t q0[$];
    exp_t q1[$];

    logic          mValid [2];
    logic [DW-1:0] mDout  [2];
    logic [1:0]    mSrc   [2];
    int            mPtr   [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    function automatic int pickWinner(logic [NC-1:0] r, int start);
        for (int i = 0; i < NC; i++) begin
            if (r[(start + i) % NC]) return (start + i) % NC;
        end
        return -1;
    endfunction

    // One cycle: drive inputs after the edge, check mid-cycle, then advance the model across the next edge.
    task automatic applyStimulus(input logic rst, input logic [NC-1:0] rq, input logic [NC*DW-1:0] dt, input logic rd);
        int       w;
        logic [3:0] expGrant;
        exp_t     e;
        @(posedge clk);
        #1;
        rstN = rst;
        ifFp.req = rq; ifRr.req = rq;
        ifFp.data_i = dt; ifRr.data_i = dt;
        ifFp.ready = rd; ifRr.ready = rd;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            w = pickWinner(rq, (d == 1) ? mPtr[d] : 0);
            expGrant = (rst && (!mValid[d] || rd) && w >= 0) ? (4'b0001 << w) : 4'b0000;
            checkOutput(d == 0 ? "fp.grant" : "rr.grant",
                        32'(d == 0 ? ifFp.grant : ifRr.grant), 32'(expGrant));
            checkOutput(d == 0 ? "fp.valid" : "rr.valid",
                        32'(d == 0 ? ifFp.valid : ifRr.valid), 32'(mValid[d]));
            checkOutput(d == 0 ? "fp.dout" : "rr.dout",
                        32'(d == 0 ? ifFp.dout : ifRr.dout), 32'(mDout[d]));
            checkOutput(d == 0 ? "fp.src_id" : "rr.src_id",
                        32'(d == 0 ? ifFp.src_id : ifRr.src_id), 32'(mSrc[d]));
            if (!rst) begin
                if (!(mValid[d] && rd)) begin
                    if (d == 0) q0.delete(); else q1.delete();
                end
                mValid[d] = 1'b0;
                mDout[d]  = '0;
                mSrc[d]   = '0;
                mPtr[d]   = 0;
            end else if (expGrant != 4'b0000) begin
                mDout[d]  = dt[w*DW +: DW];
                mSrc[d]   = 2'(w);
                mValid[d] = 1'b1;
                if (d == 1) mPtr[d] = (w + 1) % NC;
                e.data = mDout[d];
                e.src  = mSrc[d];
                if (d == 0) q0.push_back(e); else q1.push_back(e);
            end else if (mValid[d] && rd) begin
                mValid[d] = 1'b0;
            end
        end
    endtask

    // Monitor: every accepted word must match the oldest expected word of its arbiter.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (ifFp.valid && ifFp.ready) begin
                if (q0.size() == 0) begin
                    checkOutput("fp.unexpected_word", 32'(ifFp.dout), 32'hFFFF_FFFF);
                end else begin
                    e = q0.pop_front();
                    checkOutput("fp.word.dout", 32'(ifFp.dout), 32'(e.data));
                    checkOutput("fp.word.src", 32'(ifFp.src_id), 32'(e.src));
                end
            end
            if (ifRr.valid && ifRr.ready) begin
                if (q1.size() == 0) begin
                    checkOutput("rr.unexpected_word", 32'(ifRr.dout), 32'hFFFF_FFFF);
                end else begin
                    e = q1.pop_front();
                    checkOutput("rr.word.dout", 32'(ifRr.dout), 32'(e.data));
                    checkOutput("rr.word.src", 32'(ifRr.src_id), 32'(e.src));
                end
            end
        end
    end

    initial begin
        logic [NC*DW-1:0] dt;
        for (int d = 0; d < 2; d++) begin
            mValid[d] = 1'b0; mDout[d] = '0; mSrc[d] = '0; mPtr[d] = 0;
        end
        rstN = 1'b0;
        ifFp.req = '0; ifRr.req = '0;
        ifFp.data_i = '0; ifRr.data_i = '0;
        ifFp.ready = 1'b1; ifRr.ready = 1'b1;

        dt = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b1111, dt, 1'b1);
        applyStimulus(1'b1, 4'b1111, dt, 1'b1);

        dt = {16'h0033, 16'h00CC, 16'h0011, 16'h00AA};
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'b1010, dt, 1'b1);

        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 4'b1111, {4{16'(i)}} ^ 64'h0123_4567_89AB_CDEF, 1'b1);

        applyStimulus(1'b1, 4'b0011, {32'h0, 16'hBBBB, 16'hAAAA}, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'b0011, {32'h0, 16'hBBBB, 16'hA0A0}, 1'b0);
        applyStimulus(1'b1, 4'b0011, {32'h0, 16'hBBBB, 16'hC0C0}, 1'b1);

        applyStimulus(1'b1, 4'b0000, '0, 1'b1);
        applyStimulus(1'b1, 4'b0010, {32'h0, 16'h005A, 16'h0}, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'b0000, '0, 1'b1);

        applyStimulus(1'b1, 4'b0100, {16'h0, 16'h7777, 32'h0}, 1'b0);
        applyStimulus(1'b1, 4'b1111, dt, 1'b0);
        applyStimulus(1'b0, 4'b1111, dt, 1'b0);
        applyStimulus(1'b1, 4'b0000, dt, 1'b1);

        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 59) != 0), 4'($urandom),
                          {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'b0000, '0, 1'b1);

        checkOutput("fp.queue_drained", 32'(q0.size()), 32'(mValid[0] ? 1 : 0));
        checkOutput("rr.queue_drained", 32'(q1.size()), 32'(mValid[1] ? 1 : 0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule

// File: doc/mux_n_arb.md
Name: mux_n_arb

Overview:
- Parametrised N-channel registered multiplexer with arbitration and a one-entry output register using a valid/ready handshake.
- Successor to the fixed 2-input registered mux on the DDR command/data path. Adds:
  - any channel count and data width;
  - fixed-priority or round-robin arbitration;
  - per-channel grant;
  - downstream backpressure.
- Sits between the request sources (read/write/refresh command builders) and the DDR controller datapath.

Parameters:
- DATA_W, 323, width of each channel's data word.
- N_CH, 2, number of input channels (>=1).
- RR_EN, 0, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
- SRC_W, max(1, clog2(N_CH)), width of the source-index output (derived, not overridden).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req  in  N_CH  per-channel request; bit k asserted while channel k presents valid data.
- data_i  in  N_CH*DATA_W  concatenated channel data; channel k occupies bits [k*DATA_W +: DATA_W].
- grant  out  N_CH  one-hot, combinational; bit k high in the cycle channel k's data is captured.
- dout  out  DATA_W  registered output data.
- src_id  out  SRC_W  registered index of the channel that produced dout.
- valid  out  1  registered; dout/src_id hold a word not yet accepted downstream.
- ready  in  1  downstream accepts dout this cycle when valid=1.

Behaviour:
- Reset is synchronous: on a rising clk edge with rst_n=0, the following clear regardless of req/ready:
  - valid=0, dout=0, src_id=0;
  - round-robin pointer ptr=0.
  - grant is 0 while rst_n=0.
- Reset mid-transfer discards the held word; the source is not re-granted for it.
- Register free condition: free = !valid | ready.
- Load condition: load = free & |req & rst_n.
- Winner selection (combinational):
  - RR_EN=0: lowest index k with req[k]=1.
  - RR_EN=1: first k with req[k]=1, searching ptr, ptr+1, ..., N_CH-1, 0, ..., ptr-1 (wrap-around).
- grant = one-hot(winner) when load, else all zeros. A source drops req or advances to its next word only in a cycle where its grant bit is 1.
- On load, at the next edge:
  - dout <= winner's data, src_id <= winner index, valid <= 1;
  - if RR_EN=1, ptr <= winner+1, wrapping N_CH-1 -> 0.
- Pointer behaviour:
  - ptr is unchanged when there is no load.
  - With RR_EN=0, ptr is unused and held at 0.
- valid/dout update rules:
  - valid & ready & !load: valid <= 0 next edge; dout and src_id hold their last value.
  - valid & ready & load: back-to-back transfer; valid stays 1 and dout is replaced in the same edge. Sustained throughput is one word per cycle.
  - valid & !ready: stall. dout, src_id and valid hold; grant=0; ptr holds.
- Latency: req to valid is 1 cycle when the register is free.
- No combinational path from data_i to dout. grant depends combinationally on req, ready, valid and ptr.
- Degenerate N_CH=1: src_id is 1 bit, always 0. Behaves as a registered pipeline stage with handshake.
- Default configuration (N_CH=2, RR_EN=0, ready tied 1) reproduces the legacy 2-input mux:
  - channel 0 has priority;
  - valid = registered |req;
  - dout holds when idle.

Test Plan:
- Reset: drive req=all ones, ready=1, rst_n=0 for 3 cycles.
  -> valid=0, dout=0, src_id=0, grant=0 throughout. First edge after rst_n=1 -> grant=0b01, then valid=1, src_id=0.
- Fixed priority (N_CH=4, RR_EN=0): req=0b1010, ready=1 for 3 cycles, data ch1=0x11, ch3=0x33.
  -> grant=0b0010 each cycle, dout=0x11, src_id=1 every cycle. ch3 never granted.
- Round-robin fairness (N_CH=4, RR_EN=1): req=0b1111 held, ready=1 for 8 cycles.
  -> src_id sequence 0,1,2,3,0,1,2,3, one word per cycle. ptr wraps from 3 to 0.
- Backpressure (N_CH=2): load word A from ch0, hold ready=0 for 4 cycles with req=0b11.
  -> valid=1, dout=A, grant=0, ptr unchanged for 4 cycles. On ready=1 -> grant asserted the same cycle; next edge dout=new word.
- Drain to idle: single req pulse on ch1 (data 0x5A), ready=1.
  -> valid high exactly 1 cycle with dout=0x5A, src_id=1. Then valid=0 and dout still 0x5A.
- Reset mid-stall: valid=1, ready=0, assert rst_n=0 one cycle.
  -> valid=0, dout=0, ptr=0 next edge. No grant during reset cycle.
